// File: rtl/uart_bus_port.sv
// uart_bus_port: word-bus responder bridging the core to the UART through RX/TX byte FIFOs
// Ports: clk, rstn (async, active-low); addr_i/data_i/we_i/rd_i -> data_o/ack_o bus handshake;
//        uart_data_o/uart_send_o/uart_sent_i to the transmitter; uart_data_i/uart_received_i from the receiver
module uart_bus_port #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   input  logic        we_i,
   input  logic        rd_i,
   output logic        ack_o,
   output logic [7:0]  uart_data_o,
   output logic        uart_send_o,
   input  logic        uart_sent_i,
   input  logic [7:0]  uart_data_i,
   input  logic        uart_received_i
);
   localparam int CW = DEPTH_LOG2 + 1;
   localparam logic [DEPTH_LOG2:0] FULL = CW'(1 << DEPTH_LOG2);
   typedef enum logic [1:0] {IDLE, ACK, RELEASE} state_t;
   state_t state;
   logic [7:0] rx_mem [0:(1 << DEPTH_LOG2)-1];
   logic [7:0] tx_mem [0:(1 << DEPTH_LOG2)-1];
   logic [DEPTH_LOG2-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
   logic [DEPTH_LOG2:0] rx_count, tx_count;
   logic rx_ovf, tx_ovf, tx_busy;
   logic acc, wr, rd, rx_empty, rx_full, tx_empty, tx_full;
   logic rx_pop, rx_push, tx_req, tx_pop, tx_push, clr_rx, clr_tx, unused_bits;
   logic [1:0] sel;
   logic [31:0] status, rdata;
   always_comb begin
      sel = addr_i[3:2];
      acc = (state == IDLE) && (rd_i || we_i);
      wr = acc && we_i;
      rd = acc && !we_i;
      rx_empty = rx_count == '0;
      rx_full = rx_count == FULL;
      tx_empty = tx_count == '0;
      tx_full = tx_count == FULL;
      rx_pop = rd && sel == 2'd0 && !rx_empty;
      // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
      rx_push = uart_received_i && (!rx_full || rx_pop);
      tx_req = wr && sel == 2'd0;
      tx_pop = !tx_busy && !tx_empty;
      tx_push = tx_req && (!tx_full || tx_pop);
      clr_rx = wr && sel == 2'd1 && data_i[4];
      clr_tx = wr && sel == 2'd1 && data_i[5];
      status = {11'd0, 5'(tx_count), 3'd0, 5'(rx_count), 2'd0, tx_ovf, rx_ovf, tx_full, tx_empty, rx_full, rx_empty};
      rdata = sel == 2'd0 ? (rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rp]}) : sel == 2'd1 ? status : 32'd0;
      unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i[31:8]};
   end
   // the release state keeps a held request from being serviced twice
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         ack_o <= 1'b0;
         data_o <= '0;
      end else begin
         case (state)
            IDLE: if (acc) begin
               state <= ACK;
               ack_o <= 1'b1;
               if (rd) data_o <= rdata;
            end
            ACK: begin
               state <= RELEASE;
               ack_o <= 1'b0;
            end
            default: if (!rd_i && !we_i) state <= IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_wp <= '0;
         rx_rp <= '0;
         tx_wp <= '0;
         tx_rp <= '0;
         rx_count <= '0;
         tx_count <= '0;
         rx_ovf <= 1'b0;
         tx_ovf <= 1'b0;
         tx_busy <= 1'b0;
         uart_send_o <= 1'b0;
         uart_data_o <= '0;
      end else begin
         if (rx_push) rx_wp <= rx_wp + DEPTH_LOG2'(1);
         if (rx_pop) rx_rp <= rx_rp + DEPTH_LOG2'(1);
         if (tx_push) tx_wp <= tx_wp + DEPTH_LOG2'(1);
         if (tx_pop) tx_rp <= tx_rp + DEPTH_LOG2'(1);
         rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
         tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
         // a new overflow beats a clear in the same cycle
         rx_ovf <= (uart_received_i && !rx_push) || (rx_ovf && !clr_rx);
         tx_ovf <= (tx_req && !tx_push) || (tx_ovf && !clr_tx);
         tx_busy <= tx_pop || (tx_busy && !uart_sent_i);
         uart_send_o <= tx_pop;
         if (tx_pop) uart_data_o <= tx_mem[tx_rp];
      end
   end
   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wp] <= uart_data_i;
      if (tx_push) tx_mem[tx_wp] <= data_i[7:0];
   end
endmodule

// File: tb/tb_uart_bus_port.sv
// tb_uart_bus_port: scoreboard bench for uart_bus_port against a queue-based model of the register map
module tb_uart_bus_port;
   logic clk = 1'b0, rstn = 1'b0;
   logic [31:0] addr_i = '0, data_i = '0, data_o;
   logic we_i = 1'b0, rd_i = 1'b0, ack_o;
   logic [7:0] uart_data_o, uart_data_i = '0;
   logic uart_send_o, uart_sent_i = 1'b0, uart_received_i = 1'b0;
   int errors = 0, checks = 0, acks = 0;
   logic [32:0] rdq[$];
   string nmq[$];
   logic [7:0] sendq[$];
   logic [7:0] m_rx[$], m_tx[$];
   bit m_rxovf = 0, m_txovf = 0, m_inflight = 0;

   uart_bus_port dut (
      .clk(clk), .rstn(rstn), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
      .we_i(we_i), .rd_i(rd_i), .ack_o(ack_o), .uart_data_o(uart_data_o),
      .uart_send_o(uart_send_o), .uart_sent_i(uart_sent_i), .uart_data_i(uart_data_i),
      .uart_received_i(uart_received_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   function automatic logic [31:0] m_status();
      return {11'd0, 5'(m_tx.size()), 3'd0, 5'(m_rx.size()), 2'd0, m_txovf, m_rxovf,
              m_tx.size() == 16, m_tx.size() == 0, m_rx.size() == 16, m_rx.size() == 0};
   endfunction

   task automatic model_rx(input logic [7:0] b);
      if (m_rx.size() < 16) m_rx.push_back(b);
      else m_rxovf = 1;
   endtask

   function automatic logic [31:0] model_read(input logic [1:0] a);
      if (a == 2'd0) return m_rx.size() > 0 ? {24'd0, m_rx.pop_front()} : 32'd0;
      if (a == 2'd1) return m_status();
      return 32'd0;
   endfunction

   task automatic model_write(input logic [1:0] a, input logic [31:0] d);
      if (a == 2'd0) begin
         if (!m_inflight) begin
            m_inflight = 1;
            sendq.push_back(d[7:0]);
         end else if (m_tx.size() < 16) m_tx.push_back(d[7:0]);
         else m_txovf = 1;
      end else if (a == 2'd1) begin
         if (d[4]) m_rxovf = 0;
         if (d[5]) m_txovf = 0;
      end
   endtask

   task automatic bus(input bit w, input logic [1:0] a, input logic [31:0] d, input bit rx,
                      input logic [7:0] rb, input string n);
      logic [31:0] v;
      @(negedge clk);
      addr_i = {28'd0, a, 2'b00};
      data_i = d;
      we_i = w;
      rd_i = !w;
      uart_received_i = rx;
      uart_data_i = rb;
      v = '0;
      if (w) model_write(a, d);
      else v = model_read(a);
      if (rx) model_rx(rb);
      rdq.push_back({!w, v});
      nmq.push_back(n);
      @(negedge clk);
      we_i = 0;
      rd_i = 0;
      uart_received_i = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic rx_pulse(input logic [7:0] b);
      @(negedge clk);
      uart_received_i = 1;
      uart_data_i = b;
      model_rx(b);
      @(negedge clk);
      uart_received_i = 0;
   endtask

   task automatic sent_pulse();
      bit issue;
      @(negedge clk);
      uart_sent_i = 1;
      issue = m_inflight && m_tx.size() > 0;
      if (m_inflight) begin
         m_inflight = 0;
         if (m_tx.size() > 0) begin
            sendq.push_back(m_tx.pop_front());
            m_inflight = 1;
         end
      end
      @(negedge clk);
      uart_sent_i = 0;
      @(negedge clk);
      check("send_latency", {31'd0, uart_send_o}, {31'd0, issue});
      @(negedge clk);
   endtask

   task automatic hold_read();
      int a0;
      a0 = acks;
      @(negedge clk);
      addr_i = 32'h0;
      rd_i = 1;
      rdq.push_back({1'b1, model_read(2'd0)});
      nmq.push_back("hold_data");
      repeat (10) @(negedge clk);
      rd_i = 0;
      repeat (3) @(negedge clk);
      check("hold_acks", acks - a0, 1);
   endtask

   always @(negedge clk) begin
      if (ack_o) begin
         acks++;
         if (rdq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ack_o=1 expected none");
         end else begin
            logic [32:0] e;
            string n;
            e = rdq.pop_front();
            n = nmq.pop_front();
            if (e[32]) check(n, data_o, e[31:0]);
         end
      end
      if (uart_send_o) begin
         if (sendq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_send: got uart_send_o=1 data %h expected none", uart_data_o);
         end else check("tx_byte", {24'd0, uart_data_o}, {24'd0, sendq.pop_front()});
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_ack", {31'd0, ack_o}, 0);
      check("rst_data", data_o, 0);
      check("rst_send", {31'd0, uart_send_o}, 0);
      check("rst_udata", {24'd0, uart_data_o}, 0);
      rstn = 1;
      bus(0, 2'd1, 0, 0, 0, "status_reset");
      @(negedge clk);
      rd_i = 1;
      rstn = 0;
      repeat (2) begin
         @(negedge clk);
         check("abort_ack", {31'd0, ack_o}, 0);
      end
      rd_i = 0;
      rstn = 1;
      repeat (2) @(negedge clk);
      check("abort_after", {31'd0, ack_o}, 0);
      rx_pulse(8'h41);
      rx_pulse(8'h42);
      rx_pulse(8'h43);
      for (int i = 0; i < 4; i++) bus(0, 2'd0, 0, 0, 0, "rx_order");
      bus(0, 2'd1, 0, 0, 0, "status_drained");
      for (int i = 0; i < 17; i++) rx_pulse(8'($urandom));
      bus(0, 2'd1, 0, 0, 0, "status_rx_full_ovf");
      bus(1, 2'd1, 32'h10, 0, 0, "clr_rx_ovf");
      bus(0, 2'd1, 0, 0, 0, "status_after_clr");
      rx_pulse(8'h99);
      bus(1, 2'd1, 32'h10, 1, 8'h77, "clr_vs_ovf");
      bus(0, 2'd1, 0, 0, 0, "status_ovf_wins");
      bus(1, 2'd1, 32'h10, 0, 0, "clr_rx_ovf2");
      bus(0, 2'd0, 0, 1, 8'hEE, "full_rd_rx");
      bus(0, 2'd1, 0, 0, 0, "status_full_rd_rx");
      for (int i = 0; i < 16; i++) bus(0, 2'd0, 0, 0, 0, "drain_full");
      bus(0, 2'd1, 0, 0, 0, "status_empty");
      bus(0, 2'd0, 0, 1, 8'h3C, "empty_rd_rx");
      bus(0, 2'd0, 0, 0, 0, "empty_rd_rx_byte");
      rx_pulse(8'h11);
      rx_pulse(8'h22);
      hold_read();
      bus(0, 2'd1, 0, 0, 0, "status_after_hold");
      bus(0, 2'd0, 0, 0, 0, "hold_second");
      bus(1, 2'd0, 32'hA5, 0, 0, "wr_a5");
      bus(1, 2'd0, 32'h5A, 0, 0, "wr_5a");
      bus(0, 2'd1, 0, 0, 0, "status_tx_one");
      sent_pulse();
      sent_pulse();
      for (int i = 0; i < 18; i++) bus(1, 2'd0, $urandom, 0, 0, "tx_fill");
      bus(0, 2'd1, 0, 0, 0, "status_tx_full_ovf");
      bus(1, 2'd1, 32'h20, 0, 0, "clr_tx_ovf");
      bus(0, 2'd1, 0, 0, 0, "status_tx_clr");
      for (int i = 0; i < 17; i++) sent_pulse();
      bus(1, 2'd2, $urandom, 0, 0, "wr_reg2");
      bus(0, 2'd3, 0, 0, 0, "rd_reg3");
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 7))
            0: rx_pulse(8'($urandom));
            1: bus(0, 2'd0, 0, $urandom_range(0, 3) == 0, 8'($urandom), "rnd_data");
            2: bus(0, 2'd1, 0, $urandom_range(0, 3) == 0, 8'($urandom), "rnd_status");
            3: bus(1, 2'd0, $urandom, 0, 0, "rnd_wr_data");
            4: bus(1, 2'd1, $urandom, $urandom_range(0, 1) == 0, 8'($urandom), "rnd_wr_status");
            5: bus($urandom_range(0, 1) == 1, 2'($urandom_range(2, 3)), $urandom, 0, 0, "rnd_reserved");
            default: sent_pulse();
         endcase
      end
      bus(0, 2'd1, 0, 0, 0, "status_final");
      repeat (5) @(negedge clk);
      check("ack_scoreboard_empty", rdq.size(), 0);
      check("send_scoreboard_empty", sendq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
